fifo_rd_fwft: RTL and testbench

Read-domain control and output stage of the asynchronous FIFO. It consumes the write-domain Gray pointer and maintains the read pointer and empty flag. It issues reads to the synchronous-read dual-port RAM and presents data on a first-word-fall-through valid/ready interface with full throughput. It sits in the rclk domain, opposite the write-pointer/full block, and drives the Gray read pointer back to it.

---
 rtl/fifo_pkg.sv | 40 ++++
 rtl/sync_2ff.sv | 27 ++
 rtl/fifo_rd_fwft.sv | 141 ++++++++++++++
 tb/tb_fifo_rd_fwft.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and Gray/binary pointer helpers for the asynchronous FIFO.
package fifo_pkg;

  // Default RAM address width (depth = 2**ADDR_SIZE_DEF).
  localparam int unsigned ADDR_SIZE_DEF = 3;

  // Output stage holds a head word plus one skid word.
  localparam int unsigned OBUF_DEPTH = 2;

  // Widest pointer the helpers handle; callers zero-extend into this width.
  localparam int unsigned PTR_MAX_W = 32;

  // Binary to Gray. Bits at or above `width` are cleared.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b,
                                                    input int unsigned         width);
    logic [PTR_MAX_W-1:0] mask;
    logic [PTR_MAX_W-1:0] bm;
    mask = (PTR_MAX_W'(1) << width) - PTR_MAX_W'(1);
    bm   = b & mask;
    return bm ^ (bm >> 1);
  endfunction

  // Gray to binary. Bits at or above `width` are ignored, so the result is exact for
  // any pointer width up to PTR_MAX_W.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g,
                                                    input int unsigned         width);
    logic [PTR_MAX_W-1:0] mask;
    logic [PTR_MAX_W-1:0] gm;
    logic [PTR_MAX_W-1:0] b;
    mask = (PTR_MAX_W'(1) << width) - PTR_MAX_W'(1);
    gm   = g & mask;
    b    = '0;
    b[PTR_MAX_W-1] = gm[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gm[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
module sync_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // First stage may go metastable; second stage gives the settled value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/fifo_rd_fwft.sv
// Read-domain side of the asynchronous FIFO: synchronizes the write pointer, keeps the
// read pointer and empty flags, fetches from the synchronous-read RAM and presents the
// data through a two-entry first-word-fall-through output buffer.
module fifo_rd_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_SIZE     = ADDR_SIZE_DEF,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                  rclk,
  input  logic                  rrstn,
  input  logic [ADDR_SIZE:0]    wptr,
  input  logic [DATA_WIDTH-1:0] rmem_data,
  input  logic                  dout_ready,
  output logic [ADDR_SIZE:0]    rptr,
  output logic [ADDR_SIZE-1:0]  raddr,
  output logic                  rmem_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_SIZE:0]    rlevel
);

  localparam int unsigned     PTR_W         = ADDR_SIZE + 1;
  localparam logic [PTR_W-1:0] LP_AE_THRESH  = PTR_W'(AEMPTY_THRESH);
  localparam logic [2:0]       LP_OBUF_DEPTH = 3'(OBUF_DEPTH);

  // Pointer state
  logic [PTR_W-1:0] r_rbin;
  logic [PTR_W-1:0] r_rptr;
  logic             r_rempty;
  logic             r_raempty;
  logic             r_inflight;

  // Output buffer state
  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;

  // Combinational
  logic [PTR_W-1:0]      w_rq2_wptr;
  logic [PTR_W-1:0]      w_rq2_wbin;
  logic [PTR_W-1:0]      w_rbin_next;
  logic [PTR_W-1:0]      w_rgray_next;
  logic [PTR_MAX_W-1:0]  w_wbin_full;
  logic [PTR_MAX_W-1:0]  w_rgray_full;
  logic                  w_unused_hi;
  logic                  w_valid;
  logic                  w_pop;
  logic [2:0]            w_fill;
  logic                  w_fetch;
  logic [1:0]            w_occ_nxt;
  logic [DATA_WIDTH-1:0] w_head_nxt;
  logic [DATA_WIDTH-1:0] w_skid_nxt;

  sync_2ff #(
    .WIDTH (PTR_W)
  ) u_wptr_sync (
    .clk  (rclk),
    .rstn (rrstn),
    .d    (wptr),
    .q    (w_rq2_wptr)
  );

  assign w_wbin_full  = gray2bin(PTR_MAX_W'(w_rq2_wptr), PTR_W);
  assign w_rq2_wbin   = w_wbin_full[PTR_W-1:0];
  assign w_rgray_full = bin2gray(PTR_MAX_W'(w_rbin_next), PTR_W);
  assign w_rgray_next = w_rgray_full[PTR_W-1:0];
  // Helper outputs are wider than the pointer; the upper bits are always zero.
  assign w_unused_hi  = ^{w_wbin_full[PTR_MAX_W-1:PTR_W], w_rgray_full[PTR_MAX_W-1:PTR_W]};

  assign w_valid = (r_occ != 2'd0);
  assign w_pop   = w_valid & dout_ready;

  // Words that will sit in the buffer after this edge if nothing new is fetched; fetch
  // only while that leaves room, so a read in flight always has a slot to land in.
  assign w_fill  = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_fetch = ~r_rempty & (w_fill < LP_OBUF_DEPTH);

  assign w_rbin_next = r_rbin + {{ADDR_SIZE{1'b0}}, w_fetch};

  // Read pointer, flags and read-in-flight marker; the RAM slot is released on fetch.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      r_rbin     <= '0;
      r_rptr     <= '0;
      r_rempty   <= 1'b1;
      r_raempty  <= 1'b1;
      r_inflight <= 1'b0;
    end else begin
      r_rbin     <= w_rbin_next;
      r_rptr     <= w_rgray_next;
      r_rempty   <= (w_rgray_next == w_rq2_wptr);
      r_raempty  <= ((w_rq2_wbin - w_rbin_next) <= LP_AE_THRESH);
      r_inflight <= w_fetch;
    end
  end

  // Next state of the head/skid buffer: skid advances on pop, returning RAM data lands
  // in the first slot that will be free after this edge.
  always_comb begin
    w_head_nxt = r_head;
    w_skid_nxt = r_skid;
    if (w_pop && (r_occ == 2'd2)) begin
      w_head_nxt = r_skid;
    end
    if (r_inflight) begin
      if ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop)) begin
        w_head_nxt = rmem_data;
      end else begin
        w_skid_nxt = rmem_data;
      end
    end
    w_occ_nxt = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
  end

  // Output buffer registers.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      r_occ  <= 2'd0;
      r_head <= '0;
      r_skid <= '0;
    end else begin
      r_occ  <= w_occ_nxt;
      r_head <= w_head_nxt;
      r_skid <= w_skid_nxt;
    end
  end

  assign rptr          = r_rptr;
  assign raddr         = r_rbin[ADDR_SIZE-1:0];
  assign rmem_en       = w_fetch;
  assign dout          = r_head;
  assign dout_valid    = w_valid;
  assign rempty        = r_rempty;
  assign ralmost_empty = r_raempty;
  assign rlevel        = w_rq2_wbin - r_rbin;

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Bench for fifo_rd_fwft: a write-side model fills a RAM model and pushes each word to a
// scoreboard; a negedge monitor pops and compares on every accepted output word.
module tb_fifo_rd_fwft;

  localparam int PW = 4;
  localparam int DW = 8;

  logic          rclk = 1'b0;
  logic          rrstn, rrstn2;
  logic [PW-1:0] wptr;
  logic [DW-1:0] rmem_data, rmem_data2;
  logic          dout_ready, dout_ready2;

  logic [PW-1:0] rptr, rptr2, rlevel, rlevel2;
  logic [2:0]    raddr, raddr2;
  logic          rmem_en, rmem_en2, dout_valid, dout_valid2;
  logic          rempty, rempty2, ralmost_empty, ralmost_empty2;
  logic [DW-1:0] dout, dout2;

  int n_chk = 0;
  int n_bad = 0;

  logic [DW-1:0] mem [8];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] sb2[$];
  int            send_total = 0;
  int            sent = 0;
  int            pops = 0;
  int            pops2 = 0;
  int            steady = 0;
  logic          burst = 1'b0;
  logic [PW-1:0] wbin = '0;
  logic [PW-1:0] exp_rbin = '0;

  always #5 rclk = ~rclk;

  fifo_rd_fwft #(.ADDR_SIZE(3), .DATA_WIDTH(DW), .AEMPTY_THRESH(1)) dut (
    .rclk(rclk), .rrstn(rrstn), .wptr(wptr), .rmem_data(rmem_data),
    .dout_ready(dout_ready), .rptr(rptr), .raddr(raddr), .rmem_en(rmem_en),
    .dout(dout), .dout_valid(dout_valid), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .rlevel(rlevel)
  );

  fifo_rd_fwft #(.ADDR_SIZE(3), .DATA_WIDTH(DW), .AEMPTY_THRESH(2)) dut2 (
    .rclk(rclk), .rrstn(rrstn2), .wptr(wptr), .rmem_data(rmem_data2),
    .dout_ready(dout_ready2), .rptr(rptr2), .raddr(raddr2), .rmem_en(rmem_en2),
    .dout(dout2), .dout_valid(dout_valid2), .rempty(rempty2),
    .ralmost_empty(ralmost_empty2), .rlevel(rlevel2)
  );

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Synchronous-read RAM model, one port per DUT.
  always @(posedge rclk) begin
    if (rmem_en)  rmem_data  <= mem[raddr];
    if (rmem_en2) rmem_data2 <= mem[raddr2];
  end

  // Write side: writes while the RAM has room relative to the read pointer.
  initial begin : writer
    logic [PW-1:0] lvl;
    logic [DW-1:0] d;
    int            budget;
    wptr = '0;
    forever begin
      @(posedge rclk);
      #1;
      if (!rrstn) begin
        wbin = '0; wptr = '0; sent = 0; steady = 0;
      end else begin
        if (steady < 1000) steady++;
        budget = burst ? 8 : 1;
        lvl = wbin - g2b(rptr);
        while (budget > 0 && sent < send_total && lvl < 4'd8) begin
          d = DW'($urandom);
          mem[wbin[2:0]] = d;
          sb.push_back(d);
          if (rrstn2) sb2.push_back(d);
          wbin++; sent++; budget--; steady = 0;
          lvl = wbin - g2b(rptr);
        end
        wptr = b2g(wbin);
      end
    end
  end

  // Monitor: pointer sequence, steady-state flag relations and scoreboard.
  always @(negedge rclk) begin : monitor
    logic [PW-1:0] lv;
    if (!rrstn) begin
      exp_rbin = '0;
    end else begin
      chk("rptr_seq", rptr, b2g(exp_rbin));
      chk("rlevel_max", rlevel <= 4'd8, 1);
      if (steady >= 3) begin
        lv = wbin - exp_rbin;
        chk("rlevel_model", rlevel, lv);
        chk("rempty_rel", rempty, lv == 4'd0);
        chk("raempty_rel", ralmost_empty, lv <= 4'd1);
      end
      if (rmem_en) begin
        chk("raddr", raddr, exp_rbin[2:0]);
        exp_rbin++;
      end
      if (dout_valid && dout_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else chk("dout", dout, sb.pop_front());
        pops++;
      end
    end
    if (rrstn2) begin
      if (steady >= 3) begin
        chk("rempty2_rel", rempty2, rlevel2 == 4'd0);
        chk("raempty2_rel", ralmost_empty2, rlevel2 <= 4'd2);
      end
      if (dout_valid2 && dout_ready2) begin
        if (sb2.size() == 0) chk("sb2_underflow", 1, 0);
        else chk("dout2", dout2, sb2.pop_front());
        pops2++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    chk("watchdog", 0, 1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "bench timed out");
  end

  initial begin : main
    logic [DW-1:0] first_word;
    int            p0;
    int            t;
    rrstn = 1'b0; rrstn2 = 1'b0; dout_ready = 1'b0; dout_ready2 = 1'b0;
    repeat (3) @(posedge rclk);
    #1;
    chk("rst_rempty", rempty, 1);
    chk("rst_raempty", ralmost_empty, 1);
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_rptr", rptr, 0);
    chk("rst_rlevel", rlevel, 0);
    chk("rst_rmem_en", rmem_en, 0);
    rrstn = 1'b1;
    repeat (3) @(posedge rclk);

    // Single word, consumer stalled
    @(negedge rclk); send_total = 1;
    @(posedge rclk); #2;
    first_word = sb[0];
    @(posedge rclk); @(negedge rclk); chk("sw_e1_rempty", rempty, 1);
    @(posedge rclk); @(negedge rclk); chk("sw_e2_rempty", rempty, 1);
    @(posedge rclk); @(negedge rclk);
    chk("sw_e3_rempty", rempty, 0);
    chk("sw_e3_rmem_en", rmem_en, 1);
    chk("sw_e3_raddr", raddr, 0);
    @(posedge rclk); @(negedge rclk);
    chk("sw_e4_rptr", rptr, 4'b0001);
    chk("sw_e4_rempty", rempty, 1);
    @(posedge rclk); @(negedge rclk);
    chk("sw_valid", dout_valid, 1);
    chk("sw_dout", dout, first_word);
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      chk("sw_hold_valid", dout_valid, 1);
      chk("sw_hold_dout", dout, first_word);
      chk("sw_hold_rptr", rptr, 4'b0001);
      chk("sw_hold_rempty", rempty, 1);
    end

    // Second word lands in the skid entry; head must not change
    send_total = 2;
    repeat (8) @(negedge rclk);
    chk("skid_head", dout, first_word);
    chk("skid_valid", dout_valid, 1);
    chk("skid_rptr", rptr, 4'b0011);

    // Asynchronous reset with both buffer entries occupied
    #2; rrstn = 1'b0; #1;
    chk("mrst_valid", dout_valid, 0);
    chk("mrst_dout", dout, 0);
    chk("mrst_rempty", rempty, 1);
    chk("mrst_raempty", ralmost_empty, 1);
    chk("mrst_rptr", rptr, 0);
    chk("mrst_rlevel", rlevel, 0);
    chk("mrst_rmem_en", rmem_en, 0);
    sb.delete(); send_total = 0;
    repeat (2) @(posedge rclk);
    #1; rrstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      chk("post_rst_rempty", rempty, 1);
      chk("post_rst_rptr", rptr, 0);
      chk("post_rst_valid", dout_valid, 0);
    end

    // Full throughput from a preloaded full RAM
    @(negedge rclk);
    p0 = pops; dout_ready = 1'b1; burst = 1'b1; send_total = 8;
    @(posedge rclk); #2; burst = 1'b0;
    @(posedge rclk); @(posedge rclk); @(negedge rclk);
    chk("tp_full_level", rlevel, 8);
    chk("tp_full_rempty", rempty, 1);
    t = 0;
    while (!dout_valid && t < 10) begin @(negedge rclk); t++; end
    chk("tp_start", dout_valid, 1);
    for (int i = 0; i < 8; i++) begin
      chk("tp_back_to_back", dout_valid, 1);
      @(negedge rclk);
    end
    chk("tp_drained_valid", dout_valid, 0);
    chk("tp_pops", pops - p0, 8);
    chk("tp_rempty", rempty, 1);
    chk("tp_raempty", ralmost_empty, 1);
    chk("tp_rlevel", rlevel, 0);

    // Backpressure: ready toggles every cycle
    p0 = pops; send_total += 16;
    for (int c = 0; c < 300 && pops - p0 < 16; c++) begin
      @(posedge rclk); #1; dout_ready = ~dout_ready;
    end
    chk("bp_pops", pops - p0, 16);

    // Wrap-around: fill to full, then stream 40 words
    @(posedge rclk); #1;
    dout_ready = 1'b0; p0 = pops; send_total += 40;
    repeat (20) @(negedge rclk);
    chk("wr_full_level", rlevel, 8);
    chk("wr_full_rempty", rempty, 0);
    chk("wr_full_valid", dout_valid, 1);
    @(posedge rclk); #1; dout_ready = 1'b1;
    for (int c = 0; c < 400 && pops - p0 < 40; c++) @(posedge rclk);
    repeat (4) @(negedge rclk);
    chk("wr_pops", pops - p0, 40);
    chk("wr_rempty", rempty, 1);
    chk("wr_rlevel", rlevel, 0);
    chk("wr_sb_empty", sb.size(), 0);

    // Almost-empty threshold of 2 on the second instance
    @(posedge rclk); #1;
    rrstn = 1'b0; sb.delete(); sb2.delete(); send_total = 0;
    dout_ready = 1'b1; dout_ready2 = 1'b1;
    repeat (2) @(posedge rclk);
    #1; rrstn = 1'b1; rrstn2 = 1'b1;
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    p0 = pops2; burst = 1'b1; send_total = 5;
    @(posedge rclk); #2; burst = 1'b0;
    @(posedge rclk); @(posedge rclk); @(negedge rclk);
    chk("th_e2_raempty", ralmost_empty2, 1);
    @(posedge rclk); @(negedge rclk);
    chk("th_e3_raempty", ralmost_empty2, 0);
    chk("th_e3_rlevel", rlevel2, 5);
    @(posedge rclk); @(negedge rclk);
    chk("th_e4_raempty", ralmost_empty2, 0);
    @(posedge rclk); @(negedge rclk);
    chk("th_e5_raempty", ralmost_empty2, 0);
    @(posedge rclk); @(negedge rclk);
    chk("th_e6_raempty", ralmost_empty2, 1);
    chk("th_e6_rlevel", rlevel2, 2);
    for (int c = 0; c < 40 && pops2 - p0 < 5; c++) @(posedge rclk);
    repeat (2) @(negedge rclk);
    chk("th_pops", pops2 - p0, 5);
    chk("th_rptr", rptr2, 4'b0111);
    chk("th_rempty", rempty2, 1);
    chk("th_raempty_end", ralmost_empty2, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
